// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch bus between the PC/fetch stage (master) and imem (slave).
interface pc_fetch_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage for the multi-cycle 16-bit CPU:
// fetches over req/ack, holds the instruction for the ControlUnit, then advances PC on exec_done.
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_fetch_if.master  imem,
  input  logic [1:0]  pc_src_i,
  input  logic [15:0] imm_i,
  input  logic [15:0] rs_val_i,
  input  logic        exec_done_i,
  output logic [15:0] instr_o,
  output logic [3:0]  op_o,
  output logic        instr_valid_o,
  output logic [15:0] pc_o,
  output logic [15:0] pc_plus2_o,
  output logic [15:0] retired_o,
  output logic        fault_o,
  output logic [1:0]  fault_code_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] retired_q, retired_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic        req_q, req_d;

  logic [15:0] imm_x2;
  logic [15:0] next_pc;
  logic        misaligned;

  always_comb begin : next_pc_calc
    imm_x2 = imm_i << 1;
    case (pc_src_i)
      2'b01:   next_pc = pc_q + imm_x2;
      2'b10:   next_pc = (rs_val_i + imm_x2) & 16'hFFFE;
      default: next_pc = pc_q + 16'd2;
    endcase
    // Only the relative target can be odd, and only if pc itself was corrupted.
    misaligned = (pc_src_i == 2'b01) && next_pc[0];
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin : fsm_next
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    retired_d    = retired_q;
    cnt_d        = cnt_q;
    fault_code_d = fault_code_q;

    unique case (state_q)
      S_FETCH: begin
        // req_q is low only in the first cycle after reset; nothing is in flight then.
        if (req_q) begin
          if (imem.imem_ack) begin
            instr_d = imem.imem_rdata;
            cnt_d   = '0;
            state_d = S_EXEC;
          end else if (cnt_q == TIMEOUT_LAST) begin
            fault_code_d = FC_TIMEOUT;
            state_d      = S_HALT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_EXEC: begin
        if (exec_done_i) begin
          if (misaligned) begin
            fault_code_d = FC_MISALIGN;
            state_d      = S_HALT;
          end else begin
            pc_d      = next_pc;
            retired_d = retired_q + 16'd1;
            state_d   = S_FETCH;
          end
        end
      end
      S_HALT: begin
      end
      default: state_d = S_HALT;
    endcase

    req_d = (state_d == S_FETCH);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= 16'h0000;
      retired_q    <= 16'h0000;
      cnt_q        <= '0;
      fault_code_q <= FC_NONE;
      req_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      retired_q    <= retired_d;
      cnt_q        <= cnt_d;
      fault_code_q <= fault_code_d;
      req_q        <= req_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;

  assign instr_o       = instr_q;
  assign op_o          = instr_q[15:12];
  assign instr_valid_o = (state_q == S_EXEC);
  assign pc_o          = pc_q;
  assign pc_plus2_o    = pc_q + 16'd2;
  assign retired_o     = retired_q;
  assign fault_o       = (state_q == S_HALT);
  assign fault_code_o  = fault_code_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected fetch addresses are queued by the stimulus
// and matched by an independent monitor against every completed imem handshake.
module tb_pc_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic [15:0] imm, rs_val;
  logic        exec_done;
  logic [15:0] instr, pc, pc_plus2, retired;
  logic [3:0]  op;
  logic        instr_valid, fault;
  logic [1:0]  fault_code;

  pc_fetch_if bus ();

  pc_fetch_unit #(.RESET_PC(RESET_PC), .FETCH_TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (bus.master),
    .pc_src_i     (pc_src),
    .imm_i        (imm),
    .rs_val_i     (rs_val),
    .exec_done_i  (exec_done),
    .instr_o      (instr),
    .op_o         (op),
    .instr_valid_o(instr_valid),
    .pc_o         (pc),
    .pc_plus2_o   (pc_plus2),
    .retired_o    (retired),
    .fault_o      (fault),
    .fault_code_o (fault_code)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_addr_q[$];
  logic [15:0] model_pc, model_instr, model_retired;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference next-PC from the architectural rules, in wide unsigned arithmetic taken modulo 2^16.
  function automatic logic [15:0] target(input logic [1:0] src, input logic [15:0] cur,
                                         input logic [15:0] im, input logic [15:0] rs);
    longint unsigned t;
    case (src)
      2'b01:   t = longint'(cur) + 2 * longint'(im);
      2'b10: begin
        t = longint'(rs) + 2 * longint'(im);
        t = t - (t % 2);
      end
      default: t = longint'(cur) + 2;
    endcase
    return 16'(t % 65536);
  endfunction

  function automatic logic [15:0] plus2(input logic [15:0] v);
    return 16'((longint'(v) + 2) % 65536);
  endfunction

  initial begin : scoreboard_monitor
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.imem_req && bus.imem_ack) begin
        if (exp_addr_q.size() == 0) check("fetch_unexpected", 32'd1, 32'd0);
        else check("fetch_addr", {16'h0, bus.imem_addr}, {16'h0, exp_addr_q.pop_front()});
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    exec_done = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0;
    pc_src = 2'b00; imm = 16'h0; rs_val = 16'h0;
    #1;
    check("rst_req",        bus.imem_req, 0);
    check("rst_pc",         pc, RESET_PC);
    check("rst_instr",      instr, 16'h0);
    check("rst_valid",      instr_valid, 0);
    check("rst_retired",    retired, 0);
    check("rst_fault",      fault, 0);
    check("rst_fault_code", fault_code, 0);
    check("rst_pc_plus2",   pc_plus2, plus2(RESET_PC));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_addr_q.delete();
    exp_addr_q.push_back(RESET_PC);
    model_pc = RESET_PC; model_instr = 16'h0; model_retired = 16'h0;
  endtask

  task automatic mem_respond(input int waits, input logic [15:0] data, output int req_cycles);
    int   guard = 0;
    bit   stable = 1'b1;
    logic [15:0] addr0;
    req_cycles = 0;
    while (!bus.imem_req && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.imem_req) begin
      check("req_seen", 32'd0, 32'd1);
      return;
    end
    addr0 = bus.imem_addr;
    req_cycles = 1;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (bus.imem_req) req_cycles++;
      if (!bus.imem_req || bus.imem_addr !== addr0) stable = 1'b0;
    end
    check("addr_stable", stable, 1);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = data;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 16'hDEAD;
    model_instr = data;
    check("req_drop", bus.imem_req, 0);
  endtask

  task automatic exec_instr(input logic [1:0] src, input logic [15:0] im, input logic [15:0] rs,
                            input bit stray);
    check("valid",    instr_valid, 1);
    check("instr",    instr, model_instr);
    check("op",       op, model_instr[15:12]);
    check("pc",       pc, model_pc);
    check("pc_plus2", pc_plus2, plus2(model_pc));
    if (stray) begin
      bus.imem_ack = 1'b1;
      bus.imem_rdata = ~model_instr;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      check("stray_ack_instr", instr, model_instr);
      check("stray_ack_valid", instr_valid, 1);
    end
    model_pc = target(src, model_pc, im, rs);
    model_retired = model_retired + 16'd1;
    exp_addr_q.push_back(model_pc);
    pc_src = src; imm = im; rs_val = rs; exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    pc_src = 2'($urandom); imm = 16'($urandom); rs_val = 16'($urandom);
    check("retired",    retired, model_retired);
    check("valid_drop", instr_valid, 0);
  endtask

  task automatic step(input int waits, input logic [15:0] data, input logic [1:0] src,
                      input logic [15:0] im, input logic [15:0] rs, input bit stray);
    int rc;
    mem_respond(waits, data, rc);
    exec_instr(src, im, rs, stray);
  endtask

  initial begin : stimulus
    int          rc, hi;
    logic [15:0] d;
    rst_n = 1'b0;
    @(negedge clk);
    apply_reset();

    // Sequential fetches with zero wait states.
    for (int i = 0; i < 3; i++) step(0, 16'h8123, 2'b00, 16'h0, 16'h0, 1'b0);
    check("seq_retired", retired, 3);
    check("seq_pc",      pc, 16'h0006);

    // Relative jumps/branches.
    step(0, 16'h1000, 2'b01, 16'h0005, 16'h0, 1'b0);   // 0006 -> 0010
    step(0, 16'h2000, 2'b01, 16'hFFFC, 16'h0, 1'b0);   // 0010 -> 0008
    step(0, 16'h3000, 2'b01, 16'h0004, 16'h0, 1'b0);   // 0008 -> 0010
    step(0, 16'h4000, 2'b01, 16'h0005, 16'h0, 1'b0);   // 0010 -> 001A

    // Register-indirect and reserved selector.
    step(1, 16'h5000, 2'b10, 16'h0002, 16'h0101, 1'b0); // -> 0104
    step(0, 16'h6000, 2'b10, 16'h0000, 16'h0020, 1'b1); // -> 0020
    step(2, 16'h7000, 2'b11, 16'h1234, 16'hFFFF, 1'b0); // -> 0022

    // Three wait states keep req high for exactly four cycles.
    mem_respond(3, 16'h9ABC, rc);
    check("wait_req_cycles", rc, 4);
    exec_instr(2'b00, 16'h0, 16'h0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 5), 16'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 3) == 0));

    // Wrap through FFFE.
    d = 16'hFFFE - model_pc;
    step(0, 16'hA000, 2'b01, {1'b0, d[15:1]}, 16'h0, 1'b0);
    mem_respond(0, 16'hB000, rc);
    check("wrap_pc",       pc, 16'hFFFE);
    check("wrap_pc_plus2", pc_plus2, 16'h0000);
    exec_instr(2'b00, 16'h0, 16'h0, 1'b0);

    // Fetch timeout with no ack.
    hi = 0;
    while (!bus.imem_req && hi < 40) begin @(negedge clk); hi++; end
    hi = 0;
    while (bus.imem_req && hi < 40) begin hi++; @(negedge clk); end
    check("timeout_req_cycles", hi, TIMEOUT);
    check("timeout_fault",      fault, 1);
    check("timeout_code",       fault_code, 2'b10);
    check("timeout_valid",      instr_valid, 0);
    check("timeout_pc",         pc, model_pc);
    repeat (3) @(negedge clk);
    check("halt_sticky",     fault, 1);
    check("halt_req_low",    bus.imem_req, 0);

    // Ack on the last allowed cycle completes normally.
    apply_reset();
    mem_respond(TIMEOUT - 1, 16'hC000, rc);
    check("late_ack_req_cycles", rc, TIMEOUT);
    check("late_ack_fault",      fault, 0);
    exec_instr(2'b01, 16'h0020, 16'h0, 1'b0);            // -> 0040

    // Reset while a fetch is waiting.
    repeat (3) @(negedge clk);
    check("mid_fetch_req", bus.imem_req, 1);
    apply_reset();
    step(0, 16'hD000, 2'b00, 16'h0, 16'h0, 1'b0);

    // Reset while executing.
    mem_respond(1, 16'hE000, rc);
    check("mid_exec_valid", instr_valid, 1);
    apply_reset();
    step(0, 16'hF000, 2'b00, 16'h0, 16'h0, 1'b0);
    mem_respond(0, 16'h0123, rc);
    @(negedge clk);
    check("scoreboard_empty", exp_addr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and instruction-fetch stage directly upstream of the ControlUnit in the multi-cycle 16-bit CPU. It holds PC and fetches 16-bit instructions from instruction memory over a req/ack handshake. It presents the instruction and its 4-bit op field to the ControlUnit, then computes the next PC from the ControlUnit's PCsrc decision once the datapath signals completion. It also provides the jal/jalr link value and detects misaligned targets and fetch timeouts.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset; must be even.
FETCH_TIMEOUT, 15, max cycles in FETCH without imem_ack before fault; range 1..255.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_src  in  2  PCsrc from ControlUnit; sampled only on exec_done
imm  in  16  sign-extended immediate offset (instruction units, i.e. halfwords)
rs_val  in  16  register-file rs read value (jalr base)
exec_done  in  1  datapath has completed the current instruction; pc_src, imm and rs_val are valid
imem_req  out  1  instruction fetch request
imem_addr  out  16  fetch byte address
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  16  fetched instruction
instr  out  16  instruction register
op  out  4  instr[15:12], drives ControlUnit op
instr_valid  out  1  instr/op hold a live instruction
pc  out  16  address of the current instruction
pc_plus2  out  16  pc + 2, link value for jal/jalr
retired  out  16  count of completed instructions, wraps
fault  out  1  sticky fault flag
fault_code  out  2  01 misaligned target, 10 fetch timeout, 00 none

Behaviour:
- Reset (async, any state, including mid-handshake):
  - state=FETCH, pc=RESET_PC, instr=16'h0000, instr_valid=0, imem_req=0, retired=0, fault=0, fault_code=00, timeout counter=0.
  - imem_req rises on the first clock edge after rst_n deasserts; a handshake in flight is abandoned.
- States: FETCH, EXEC, HALT.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until ack.
  - On an edge with imem_ack=1: instr<=imem_rdata, counter<=0, next state EXEC.
  - Otherwise the counter increments. If imem_ack is still 0 when the counter reaches FETCH_TIMEOUT, go to HALT with fault_code=10.
  - An ack arriving on the same edge as the timeout wins: the fetch completes normally.
- EXEC:
  - imem_req=0 and instr_valid=1.
  - Any imem_ack seen while imem_req=0 is ignored.
  - Waits indefinitely for exec_done.
  - On exec_done: pc<=next_pc, retired<=retired+1, next state FETCH.
  - instr_valid drops in the cycle after exec_done. There is no back-to-back fetch, so latency is a minimum of 2 cycles per instruction, plus memory wait states.
- next_pc, 16-bit arithmetic with overflow wrapping silently:
  - pc_src=00: pc+2 (sequential; also not-taken beq/ble).
  - pc_src=01: pc + (imm<<1) (jal, taken beq/ble).
  - pc_src=10: (rs_val + (imm<<1)) & 16'hFFFE (jalr; bit 0 forced clear, never faults).
  - pc_src=11: reserved, treated as 00.
- Misalignment: if the 01 target has bit 0 set, go to HALT with fault_code=01. Because imm<<1 is always even, this fault is reachable only through a corrupted pc. pc is not updated and retired is not incremented.
- pc_plus2 = pc+2 combinationally at all times; 16'hFFFE+2 wraps to 16'h0000.
- HALT: imem_req=0, instr_valid=0, fault=1, pc frozen at the faulting instruction. Exit only by reset.
- op = instr[15:12] combinationally. instr holds its value after EXEC until the next ack overwrites it.
- retired wraps from 16'hFFFF to 16'h0000 without fault.

Test Plan:
- Reset then sequential: mem returns 16'h8123 with 0 wait states, exec_done pulsed each EXEC -> imem_addr 0000, 0002, 0004; op=4'b1000; retired=3; pc_plus2=0006.
- jal/branch: pc=0010, pc_src=01, imm=16'hFFFC on exec_done -> next fetch at 0008; with imm=0005 -> fetch at 001A.
- jalr: rs_val=0101, imm=0002, pc_src=10 -> fetch at 0104 (bit 0 cleared); pc_src=11 from pc=0020 -> fetch at 0022.
- Wait states and timeout: ack after 3 cycles -> imem_req high for exactly 4 cycles with addr stable. No ack with FETCH_TIMEOUT=15 -> fault=1, fault_code=10 after 15 cycles, req low. Ack on the 15th cycle -> normal EXEC, no fault.
- Reset mid-operation: assert rst_n=0 during FETCH wait and during EXEC -> outputs hit reset values immediately (asynchronously); after release, the first fetch is at RESET_PC.
- Wrap: pc=FFFE, pc_src=00 -> fetch at 0000, pc_plus2=0000 while at FFFE; retired preset via 65536 completions wraps to 0; stray imem_ack during EXEC leaves instr unchanged.
